// File: rtl/alu_muldiv.sv
// alu_muldiv: radix-2 iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes.
// Operands are reduced to magnitudes at accept; the sign is applied in one extra cycle after the last step.
module alu_muldiv #(
    parameter int XLEN = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            negative,
    output logic            zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [2:0] op_r;
    logic neg_r, spec_r;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] opnd;
    logic [2*XLEN-1:0] prod;
    logic s1, s2, neg1, neg2, div0, ovf;
    logic [XLEN-1:0] a1, a2, spec_val, v, fin;
    logic [XLEN:0] sum, r, diff;
    logic [2*XLEN-1:0] step, p;
    assign s1 = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign s2 = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign neg1 = s1 && in1[XLEN-1];
    assign neg2 = s2 && in2[XLEN-1];
    assign a1 = neg1 ? -in1 : in1;
    assign a2 = neg2 ? -in2 : in2;
    assign div0 = op[2] && (in2 == '0);
    assign ovf = op[2] && !op[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
    assign spec_val = div0 ? (op[1] ? in1 : '1) : (op[1] ? '0 : in1);
    // prod holds {high/remainder, low/quotient}; mul shifts right, div shifts left
    assign sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    assign r = prod[2*XLEN-1:XLEN-1];
    assign diff = r - {1'b0, opnd};
    assign step = op_r[2] ? {diff[XLEN] ? r[XLEN-1:0] : diff[XLEN-1:0], prod[XLEN-2:0], ~diff[XLEN]}
                          : {sum, prod[XLEN-1:1]};
    assign p = neg_r ? -prod : prod;
    assign v = op_r[1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    assign fin = spec_r ? prod[XLEN-1:0] :
                 op_r[2] ? (neg_r ? -v : v) :
                 (op_r[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    assign negative = result[XLEN-1];
    assign zero = result == '0;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            result <= '0;
            cnt <= '0;
            op_r <= '0;
            neg_r <= 1'b0;
            spec_r <= 1'b0;
            opnd <= '0;
            prod <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= CALC;
                    in_ready <= 1'b0;
                    op_r <= op;
                    neg_r <= (op[2] && op[1]) ? neg1 : neg1 ^ neg2;
                    spec_r <= div0 || ovf;
                    cnt <= (div0 || ovf) ? '0 : CNT_W'(XLEN);
                    opnd <= op[2] ? a2 : a1;
                    prod <= {{XLEN{1'b0}}, (div0 || ovf) ? spec_val : (op[2] ? a1 : a2)};
                end
                CALC: if (cnt != '0) begin
                    prod <= step;
                    cnt <= cnt - 1'b1;
                end else begin
                    result <= fin;
                    out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
